// File: rtl/mem_access_stage_pkg.sv
// Shared pipeline definitions: reset PC, load-op encodings and MEM-stage FSM states.
package mem_access_stage_pkg;

    localparam logic [31:0] PIPE_RESET_PC = 32'h1c000000;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_B    = 3'd1,
        LD_H    = 3'd2,
        LD_W    = 3'd3,
        LD_BU   = 3'd4,
        LD_HU   = 3'd5
    } load_op_e;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WAIT = 2'd1,
        MS_DONE = 2'd2
    } ms_state_e;

    // Encodings 6 and 7 are reserved and behave as "no load".
    function automatic logic is_load(input logic [2:0] op);
        return (op >= LD_B) && (op <= LD_HU);
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align_ext.sv
// Extracts the addressed byte/halfword from a 32-bit read word and sign/zero-extends it.
module load_align_ext
    import mem_access_stage_pkg::*;
(
    input  logic [2:0]  load_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = raw[7:0];
            2'd1:    byte_sel = raw[15:8];
            2'd2:    byte_sel = raw[23:16];
            default: byte_sel = raw[31:24];
        endcase
        // Halfword select ignores addr[0]; misaligned halves are not faulted.
        half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];

        case (load_op)
            LD_B:    data = {{24{byte_sel[7]}}, byte_sel};
            LD_H:    data = {{16{half_sel[15]}}, half_sel};
            LD_BU:   data = {24'd0, byte_sel};
            LD_HU:   data = {16'd0, half_sel};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: holds one instruction, waits for the data SRAM response on loads
// and buffers the word when WB stalls so the response is never lost.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PIPE_RESET_PC
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        es_to_ms_valid,
    input  logic [31:0] es_pc,
    input  logic [3:0]  es_rf_we,
    input  logic [4:0]  es_rf_waddr,
    input  logic [31:0] es_alu_result,
    input  logic [2:0]  es_load_op,
    input  logic        data_sram_rvalid,
    input  logic [31:0] data_sram_rdata,
    input  logic        ws_allow_in,
    output logic        ms_allow_in,
    output logic        ms_to_ws_valid,
    output logic [31:0] ms_pc,
    output logic [3:0]  ms_rf_we,
    output logic [4:0]  ms_rf_waddr,
    output logic [31:0] ms_rf_wdata,
    output logic        ms_fwd_valid,
    output logic        ms_fwd_busy
);

    ms_state_e   state, state_nxt;
    logic        ms_valid;
    logic        ms_ready_go;
    logic [31:0] ms_alu_result;
    logic [2:0]  ms_load_op;
    logic [31:0] ld_buf;
    logic [31:0] raw_data;
    logic [31:0] ext_data;
    logic        accept_load;

    assign ms_allow_in    = !ms_valid || (ms_ready_go && ws_allow_in);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign ms_fwd_valid   = ms_valid && (ms_rf_we != 4'd0);
    assign accept_load    = ms_allow_in && es_to_ms_valid && is_load(es_load_op);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid      <= 1'b0;
            ms_pc         <= RESET_PC;
            ms_rf_we      <= 4'd0;
            ms_rf_waddr   <= 5'd0;
            ms_alu_result <= 32'd0;
            ms_load_op    <= 3'd0;
        end else if (ms_allow_in) begin
            ms_valid      <= es_to_ms_valid;
            ms_pc         <= es_pc;
            ms_rf_we      <= es_rf_we;
            ms_rf_waddr   <= es_rf_waddr;
            ms_alu_result <= es_alu_result;
            ms_load_op    <= es_load_op;
        end
    end

    // Response arrived while WB is stalled: keep it until WB takes the instruction.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            ld_buf <= 32'd0;
        else if (state == MS_WAIT && data_sram_rvalid && !ws_allow_in)
            ld_buf <= data_sram_rdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= MS_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (ms_allow_in)
            state_nxt = accept_load ? MS_WAIT : MS_IDLE;
        else if (state == MS_WAIT && data_sram_rvalid)
            state_nxt = MS_DONE;
    end

    always_comb begin
        ms_ready_go = 1'b1;
        raw_data    = ld_buf;
        ms_fwd_busy = 1'b0;
        case (state)
            MS_WAIT: begin
                ms_ready_go = data_sram_rvalid;
                raw_data    = data_sram_rdata;
                ms_fwd_busy = ms_valid && !data_sram_rvalid;
            end
            default: ;
        endcase
    end

    load_align_ext u_load_align_ext (
        .load_op (ms_load_op),
        .addr_lo (ms_alu_result[1:0]),
        .raw     (raw_data),
        .data    (ext_data)
    );

    assign ms_rf_wdata = is_load(ms_load_op) ? ext_data : ms_alu_result;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed scenarios plus randomized traffic against a transaction-level model of the MEM stage.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        es_to_ms_valid;
    logic [31:0] es_pc;
    logic [3:0]  es_rf_we;
    logic [4:0]  es_rf_waddr;
    logic [31:0] es_alu_result;
    logic [2:0]  es_load_op;
    logic        data_sram_rvalid;
    logic [31:0] data_sram_rdata;
    logic        ws_allow_in;
    logic        ms_allow_in;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic [3:0]  ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic [31:0] ms_rf_wdata;
    logic        ms_fwd_valid;
    logic        ms_fwd_busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the single instruction slot and whether its load data is already held.
    logic        m_valid, m_have;
    logic [31:0] m_pc, m_alu, m_buf;
    logic [3:0]  m_we;
    logic [4:0]  m_waddr;
    int          m_op;

    logic [31:0] ld_pc   [4];
    int          ld_op   [4];
    logic [31:0] ld_addr [4];
    logic [31:0] ld_data [4];

    mem_access_stage dut (
        .clk              (clk),
        .resetn           (resetn),
        .es_to_ms_valid   (es_to_ms_valid),
        .es_pc            (es_pc),
        .es_rf_we         (es_rf_we),
        .es_rf_waddr      (es_rf_waddr),
        .es_alu_result    (es_alu_result),
        .es_load_op       (es_load_op),
        .data_sram_rvalid (data_sram_rvalid),
        .data_sram_rdata  (data_sram_rdata),
        .ws_allow_in      (ws_allow_in),
        .ms_allow_in      (ms_allow_in),
        .ms_to_ws_valid   (ms_to_ws_valid),
        .ms_pc            (ms_pc),
        .ms_rf_we         (ms_rf_we),
        .ms_rf_waddr      (ms_rf_waddr),
        .ms_rf_wdata      (ms_rf_wdata),
        .ms_fwd_valid     (ms_fwd_valid),
        .ms_fwd_busy      (ms_fwd_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Value written back for an instruction: extracted/extended load data, or the ALU result.
    function automatic logic [31:0] ref_wdata(input int op, input logic [31:0] addr,
                                              input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * addr[1:0])) & 32'hff;
        h = (w >> (16 * addr[1])) & 32'hffff;
        case (op)
            1:       return (b >= 32'd128)   ? b - 32'd256   : b;
            2:       return (h >= 32'd32768) ? h - 32'd65536 : h;
            3:       return w;
            4:       return b;
            5:       return h;
            default: return addr;
        endcase
    endfunction

    task automatic next();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] pc, input logic [2:0] op, input logic [31:0] alu);
        es_to_ms_valid = 1'b1;
        es_pc          = pc;
        es_load_op     = op;
        es_alu_result  = alu;
        es_rf_we       = 4'hf;
        es_rf_waddr    = 5'd7;
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_have = 1'b0; m_pc = PIPE_RESET_PC;
        m_alu = '0; m_buf = '0; m_we = '0; m_waddr = '0; m_op = 0;
    endtask

    task automatic random_phase(input int cycles);
        bit          loading, ready, allow;
        logic [31:0] raw;
        for (int i = 0; i < cycles; i++) begin
            if (i == cycles / 2) begin
                resetn = 1'b0;
                #1;
                chk("rnd_rst_allow", 32'(ms_allow_in), 32'd1);
                chk("rnd_rst_tows",  32'(ms_to_ws_valid), 32'd0);
                chk("rnd_rst_pc",    ms_pc, PIPE_RESET_PC);
                model_reset();
                next();
                resetn = 1'b1;
            end
            es_to_ms_valid   = 1'($urandom_range(0, 3) != 0);
            es_pc            = $urandom;
            es_load_op       = 3'($urandom_range(0, 7));
            es_alu_result    = $urandom;
            es_rf_we         = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            es_rf_waddr      = 5'($urandom);
            data_sram_rvalid = 1'($urandom_range(0, 2) != 0);
            data_sram_rdata  = $urandom;
            ws_allow_in      = 1'($urandom_range(0, 3) != 0);
            #1;
            loading = m_valid && m_op >= 1 && m_op <= 5;
            ready   = !loading || m_have || data_sram_rvalid;
            allow   = !m_valid || (ready && ws_allow_in);
            raw     = m_have ? m_buf : data_sram_rdata;
            chk("rnd_allow", 32'(ms_allow_in),    32'(allow));
            chk("rnd_tows",  32'(ms_to_ws_valid), 32'(m_valid && ready));
            chk("rnd_busy",  32'(ms_fwd_busy),    32'(loading && !m_have && !data_sram_rvalid));
            chk("rnd_fwd",   32'(ms_fwd_valid),   32'(m_valid && m_we != 4'd0));
            if (m_valid && ready) begin
                chk("rnd_pc",    ms_pc, m_pc);
                chk("rnd_we",    32'(ms_rf_we), 32'(m_we));
                chk("rnd_waddr", 32'(ms_rf_waddr), 32'(m_waddr));
                chk("rnd_wdata", ms_rf_wdata, ref_wdata(loading ? m_op : 0, m_alu, raw));
            end
            @(posedge clk);
            if (allow) begin
                m_valid = es_to_ms_valid; m_pc = es_pc; m_we = es_rf_we;
                m_waddr = es_rf_waddr; m_alu = es_alu_result; m_op = int'(es_load_op);
                m_have  = 1'b0;
            end else if (loading && !m_have && data_sram_rvalid) begin
                m_have = 1'b1;
                m_buf  = data_sram_rdata;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        resetn = 1'b1;
        es_to_ms_valid = 0; es_pc = '0; es_rf_we = '0; es_rf_waddr = '0;
        es_alu_result = '0; es_load_op = '0;
        data_sram_rvalid = 0; data_sram_rdata = '0; ws_allow_in = 1'b1;
        #2 resetn = 1'b0;
        #1;
        chk("rst_allow", 32'(ms_allow_in), 32'd1);
        chk("rst_tows",  32'(ms_to_ws_valid), 32'd0);
        chk("rst_fwd",   32'(ms_fwd_valid), 32'd0);
        chk("rst_pc",    ms_pc, PIPE_RESET_PC);
        @(negedge clk);
        next();
        resetn = 1'b1;

        // Non-load passes straight through.
        issue(32'h1c000004, 3'd0, 32'h12345678);
        #1 chk("nl_allow", 32'(ms_allow_in), 32'd1);
        next();
        es_to_ms_valid = 1'b0;
        #1;
        chk("nl_tows",  32'(ms_to_ws_valid), 32'd1);
        chk("nl_wdata", ms_rf_wdata, 32'h12345678);
        chk("nl_pc",    ms_pc, 32'h1c000004);
        chk("nl_fwd",   32'(ms_fwd_valid), 32'd1);

        // LD_B / LD_BU on byte 3.
        next();
        issue(32'h1c000008, LD_B, 32'h00000003);
        next();
        es_to_ms_valid = 1'b0; data_sram_rvalid = 1'b1; data_sram_rdata = 32'h80FF0000;
        #1;
        chk("ldb_tows",  32'(ms_to_ws_valid), 32'd1);
        chk("ldb_wdata", ms_rf_wdata, 32'hFFFFFF80);
        next();
        data_sram_rvalid = 1'b0;
        issue(32'h1c00000c, LD_BU, 32'h00000003);
        next();
        es_to_ms_valid = 1'b0; data_sram_rvalid = 1'b1;
        #1 chk("ldbu_wdata", ms_rf_wdata, 32'h00000080);

        // LD_H upper half with a 3-cycle response.
        next();
        data_sram_rvalid = 1'b0;
        issue(32'h1c000010, LD_H, 32'h00000002);
        next();
        es_to_ms_valid = 1'b0;
        #1;
        chk("ldh_allow1", 32'(ms_allow_in), 32'd0);
        chk("ldh_busy1",  32'(ms_fwd_busy), 32'd1);
        next();
        #1;
        chk("ldh_allow2", 32'(ms_allow_in), 32'd0);
        chk("ldh_busy2",  32'(ms_fwd_busy), 32'd1);
        next();
        data_sram_rvalid = 1'b1; data_sram_rdata = 32'h7FFF1234;
        #1;
        chk("ldh_busy3", 32'(ms_fwd_busy), 32'd0);
        chk("ldh_tows",  32'(ms_to_ws_valid), 32'd1);
        chk("ldh_wdata", ms_rf_wdata, 32'h00007FFF);

        // LD_W returns while WB is stalled; word is buffered, stray responses ignored.
        next();
        data_sram_rvalid = 1'b0;
        issue(32'h1c000014, LD_W, 32'h00000004);
        next();
        issue(32'h1c000100, 3'd0, 32'hAAAA5555);
        data_sram_rvalid = 1'b1; data_sram_rdata = 32'hCAFEBABE; ws_allow_in = 1'b0;
        #1;
        chk("ldw_tows",   32'(ms_to_ws_valid), 32'd1);
        chk("ldw_wdata0", ms_rf_wdata, 32'hCAFEBABE);
        chk("ldw_allow0", 32'(ms_allow_in), 32'd0);
        next();
        data_sram_rdata = 32'h11111111;
        #1;
        chk("ldw_state",  32'(dut.state), 32'(MS_DONE));
        chk("ldw_wdata1", ms_rf_wdata, 32'hCAFEBABE);
        chk("ldw_allow1", 32'(ms_allow_in), 32'd0);
        next();
        data_sram_rvalid = 1'b0;
        #1;
        chk("ldw_wdata2", ms_rf_wdata, 32'hCAFEBABE);
        chk("ldw_pc2",    ms_pc, 32'h1c000014);
        next();
        ws_allow_in = 1'b1;
        #1;
        chk("ldw_allow3", 32'(ms_allow_in), 32'd1);
        chk("ldw_wdata3", ms_rf_wdata, 32'hCAFEBABE);
        next();
        es_to_ms_valid = 1'b0;
        #1;
        chk("ldw_nl_pc",    ms_pc, 32'h1c000100);
        chk("ldw_nl_wdata", ms_rf_wdata, 32'hAAAA5555);

        // Back-to-back loads, one result per cycle.
        for (int k = 0; k < 4; k++) begin
            ld_pc[k]   = 32'h1c000200 + 32'(4 * k);
            ld_op[k]   = $urandom_range(1, 5);
            ld_addr[k] = $urandom;
            ld_data[k] = $urandom;
        end
        next();
        for (int k = 0; k <= 4; k++) begin
            if (k < 4) issue(ld_pc[k], 3'(ld_op[k]), ld_addr[k]);
            else       es_to_ms_valid = 1'b0;
            data_sram_rvalid = (k > 0);
            data_sram_rdata  = (k > 0) ? ld_data[k-1] : 32'd0;
            #1;
            if (k > 0) begin
                chk("b2b_state", 32'(dut.state), 32'(MS_WAIT));
                chk("b2b_tows",  32'(ms_to_ws_valid), 32'd1);
                chk("b2b_allow", 32'(ms_allow_in), 32'd1);
                chk("b2b_pc",    ms_pc, ld_pc[k-1]);
                chk("b2b_wdata", ms_rf_wdata, ref_wdata(ld_op[k-1], ld_addr[k-1], ld_data[k-1]));
            end
            next();
        end

        // Reset in the middle of a pending load; the late response must be dropped.
        data_sram_rvalid = 1'b0;
        issue(32'h1c000300, LD_W, 32'h0);
        next();
        es_to_ms_valid = 1'b0;
        #1 chk("mid_busy", 32'(ms_fwd_busy), 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_tows",  32'(ms_to_ws_valid), 32'd0);
        chk("mid_rst_allow", 32'(ms_allow_in), 32'd1);
        chk("mid_rst_fwd",   32'(ms_fwd_valid), 32'd0);
        chk("mid_rst_pc",    ms_pc, PIPE_RESET_PC);
        next();
        resetn = 1'b1; data_sram_rvalid = 1'b1; data_sram_rdata = 32'hDEADBEEF;
        #1;
        chk("stray_tows", 32'(ms_to_ws_valid), 32'd0);
        chk("stray_busy", 32'(ms_fwd_busy), 32'd0);
        chk("stray_pc",   ms_pc, PIPE_RESET_PC);
        next();
        data_sram_rvalid = 1'b0;
        #1 chk("stray_tows2", 32'(ms_to_ws_valid), 32'd0);

        // Randomized traffic against the model (includes one mid-run reset).
        resetn = 1'b0;
        #1;
        model_reset();
        next();
        resetn = 1'b1;
        random_phase(1500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
